// File: rtl/rom_stream_pkg.sv
// Shared types and sizing for the ROM stream reader.
// FSM states and output-buffer depth.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int FIFO_DEPTH  = 4;
    localparam int ISSUE_LIMIT = FIFO_DEPTH - 1;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream leaving the ROM stream reader.
// master drives data/valid, slave drives ready.
interface rom_stream_reader_if #(
    parameter int Data_Width = 8
);

    logic [Data_Width-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO buffering ROM words for the output stream.
// Push and pop may coincide at any occupancy; rst flushes contents.
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [Data_Width-1:0] push_data,
    input  logic                  pop,
    output logic [2:0]            count,
    output logic [Data_Width-1:0] head
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] FULL = 3'(FIFO_DEPTH);

    logic [Data_Width-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Issues ROM reads for a (base, len) command and streams the returned
// words out with backpressure, hiding the ROM's one-cycle read latency.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Addr_Width-1:0] base,
    input  logic [Addr_Width:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [Addr_Width-1:0] rom_addr,
    input  logic [Data_Width-1:0] rom_dout,
    rom_stream_reader_if.master   m
);

    localparam logic [Addr_Width-1:0] A_ONE = Addr_Width'(1);
    localparam logic [Addr_Width:0]   L_ONE = (Addr_Width + 1)'(1);
    localparam logic [3:0]            LIMIT = 4'(ISSUE_LIMIT);

    state_t                state;
    logic [Addr_Width-1:0] next_addr;
    logic [Addr_Width:0]   remaining;
    logic                  req_q;
    logic                  rd_q;
    logic [2:0]            fifo_count;
    logic [Data_Width-1:0] fifo_head;
    logic                  pop;
    logic [3:0]            inflight;
    logic                  can_issue;
    logic                  last_pop;

    rom_stream_fifo #(
        .Data_Width (Data_Width)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_q),
        .push_data (rom_dout),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign m.m_valid = (fifo_count != 3'd0);
    assign m.m_data  = fifo_head;
    assign pop       = m.m_valid && m.m_ready;
    assign busy      = (state != IDLE);

    // Words already buffered plus those still in the ROM pipeline
    // must leave room for one more, so the buffer can never overflow.
    assign inflight  = 4'(fifo_count) + 4'(req_q) + 4'(rd_q);
    assign can_issue = (remaining != '0) && (inflight <= LIMIT);
    assign last_pop  = pop && (fifo_count == 3'd1) && !req_q && !rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            next_addr <= '0;
            remaining <= '0;
            rom_addr  <= '0;
            req_q     <= 1'b0;
            rd_q      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_q  <= req_q;
            req_q <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rom_addr  <= base;
                            req_q     <= 1'b1;
                            next_addr <= base + A_ONE;
                            remaining <= len - L_ONE;
                            state     <= (len == L_ONE) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        rom_addr  <= next_addr;
                        req_q     <= 1'b1;
                        next_addr <= next_addr + A_ONE;
                        remaining <= remaining - L_ONE;
                        if (remaining == L_ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench: reader paired with a registered ROM holding data = address.
// Each task drives one scenario and checks cycle-exact outputs inline.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic [3:0] rom_addr;
    logic [7:0] rom_dout;

    int checks = 0;
    int errors = 0;

    rom_stream_reader_if #(.Data_Width(8)) s_if ();

    rom_stream_reader #(
        .Data_Width (8),
        .Addr_Width (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .m        (s_if.master)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_dout <= {4'h0, rom_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        len = '0;
        s_if.m_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (rom_addr !== 4'd0) begin
            errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr);
        end
        checks++;
        if (s_if.m_data !== 8'd0) begin
            errors++; $display("FAIL reset_m_data got %0d exp 0", s_if.m_data);
        end
        checks++;
        if (s_if.m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid got %b exp 0", s_if.m_valid);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start = 1'b1; base = 4'd3; len = 5'd4;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 4'd3) begin
            errors++;
            $display("FAIL basic_issue got busy=%b addr=%0d exp busy=1 addr=3", busy, rom_addr);
        end
        for (int k = 2; k <= 7; k++) begin
            tick();
            if (k == 2) begin
                checks++;
                if (s_if.m_valid !== 1'b0) begin
                    errors++; $display("FAIL basic_early_valid got %b exp 0", s_if.m_valid);
                end
            end else if (k <= 6) begin
                checks++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'(k)) begin
                    errors++;
                    $display("FAIL basic_data cyc=%0d got v=%b d=%0d exp v=1 d=%0d",
                             k, s_if.m_valid, s_if.m_data, k);
                end
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || s_if.m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done got done=%b busy=%b v=%b exp 1 0 0",
                             done, busy, s_if.m_valid);
                end
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse got %b exp 0", done);
        end
    endtask

    task automatic test_wrap();
        start = 1'b1; base = 4'd14; len = 5'd4;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            logic [3:0] ea;
            logic [7:0] ed;
            ea = 4'(14 + k - 1);
            ed = 8'((14 + k - 3) % 16);
            if (k <= 4) begin
                checks++;
                if (rom_addr !== ea) begin
                    errors++;
                    $display("FAIL wrap_addr cyc=%0d got %0d exp %0d", k, rom_addr, ea);
                end
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== ed) begin
                    errors++;
                    $display("FAIL wrap_data cyc=%0d got v=%b d=%0d exp v=1 d=%0d",
                             k, s_if.m_valid, s_if.m_data, ed);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int done_cyc = -1;
        start = 1'b1; base = 4'd0; len = 5'd16;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            s_if.m_ready = !(k >= 4 && k <= 10);
            if (s_if.m_valid && s_if.m_ready) begin
                checks++;
                if (s_if.m_data !== 8'(idx)) begin
                    errors++;
                    $display("FAIL bp_order cyc=%0d got %0d exp %0d", k, s_if.m_data, idx);
                end
                idx++;
            end
            if (k >= 3 && k <= 25) begin
                checks++;
                if (s_if.m_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_bubble cyc=%0d got v=0 exp v=1", k);
                end
            end
            if (k == 10) begin
                checks++;
                if (rom_addr !== 4'd4) begin
                    errors++; $display("FAIL bp_stall got addr=%0d exp 4", rom_addr);
                end
            end
            if (done && done_cyc < 0) done_cyc = k;
            tick();
        end
        s_if.m_ready = 1'b1;
        checks++;
        if (idx != 16) begin
            errors++; $display("FAIL bp_count got %0d exp 16", idx);
        end
        checks++;
        if (done_cyc != 26) begin
            errors++; $display("FAIL bp_done_cycle got %0d exp 26", done_cyc);
        end
    endtask

    task automatic test_len_zero();
        start = 1'b1; base = 4'd7; len = 5'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b v=%b exp 1 0 0",
                     done, busy, s_if.m_valid);
        end
        checks++;
        if (rom_addr !== 4'd15) begin
            errors++; $display("FAIL zero_no_req got addr=%0d exp 15", rom_addr);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if (s_if.m_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_quiet cyc=%0d got v=%b done=%b exp 0 0",
                         k, s_if.m_valid, done);
            end
        end
    endtask

    task automatic test_start_ignored();
        int idx = 0;
        int done_cyc = -1;
        start = 1'b1; base = 4'd2; len = 5'd3;
        tick();
        base = 4'd9; len = 5'd5;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) start = 1'b0;
            if (s_if.m_valid && s_if.m_ready) begin
                checks++;
                if (s_if.m_data !== 8'(2 + idx)) begin
                    errors++;
                    $display("FAIL ign_data cyc=%0d got %0d exp %0d", k, s_if.m_data, 2 + idx);
                end
                idx++;
            end
            if (done && done_cyc < 0) done_cyc = k;
            tick();
        end
        checks++;
        if (idx != 3 || done_cyc != 6) begin
            errors++;
            $display("FAIL ign_total got words=%0d done=%0d exp 3 6", idx, done_cyc);
        end
        checks++;
        if (busy !== 1'b0 || rom_addr !== 4'd4) begin
            errors++;
            $display("FAIL ign_final got busy=%b addr=%0d exp 0 4", busy, rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int done_cyc = -1;
        start = 1'b1; base = 4'd0; len = 5'd8;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (s_if.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got v=%b busy=%b done=%b exp 0 0 0",
                     s_if.m_valid, busy, done);
        end
        checks++;
        if (rom_addr !== 4'd0 || s_if.m_data !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_regs got addr=%0d d=%0d exp 0 0", rom_addr, s_if.m_data);
        end
        start = 1'b1; base = 4'd5; len = 5'd2;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (s_if.m_valid && s_if.m_ready) begin
                checks++;
                if (s_if.m_data !== 8'(5 + idx)) begin
                    errors++;
                    $display("FAIL rstmid_data cyc=%0d got %0d exp %0d", k, s_if.m_data, 5 + idx);
                end
                idx++;
            end
            if (done && done_cyc < 0) done_cyc = k;
            tick();
        end
        checks++;
        if (idx != 2 || done_cyc != 5) begin
            errors++;
            $display("FAIL rstmid_total got words=%0d done=%0d exp 2 5", idx, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
